lc3_useq: RTL and testbench
===========================

Name: lc3_useq

Overview:
- Parametrised microsequencer for the LC-3 Patt microarchitecture.
- Owns the registered micro-address, the BEN latch, the interrupt-pending latch and a memory-wait timeout.
- Computes the next micro-address from the microinstruction's IRD/COND/J fields.
- Sits between the control store and the CPU datapath. It replaces the fixed 6-bit next-address logic with a width-generic sequencer that adds timeout recovery and an optional micro-call stack.

Parameters:
- UADDR_W, 6: micro-address width. Must be >= 6.
- RESET_UADDR, 18: micro-address loaded on reset (fetch state).
- ERR_UADDR, 63: micro-address taken on memory timeout.
- MEM_TIMEOUT, 16: maximum consecutive not-ready cycles while waiting on memory. Must be >= 2.
- STACK_DEPTH, 4: micro-call stack entries. Used only with USEQ_CALL_STACK_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- c_ird  in  1  instruction-register decode dispatch
- c_cond  in  3  branch condition select
- c_j  in  UADDR_W  microinstruction J field
- c_ld_ben  in  1  latch BEN this cycle
- ir  in  16  instruction register
- cc_n, cc_z, cc_p  in  1 each  condition codes
- priv  in  1  PSR[15]
- mem_rdy  in  1  memory ready
- int_int  in  1  interrupt request, level
- int_ack  in  1  clears interrupt pending
- uaddr  out  UADDR_W  current micro-address; drives control-store address
- ben  out  1  latched branch-enable
- int_pend  out  1  interrupt pending
- mem_err  out  1  sticky memory-timeout flag
- stack_err  out  1  sticky stack over/underflow flag; tied 0 without the feature

Behaviour:
- Reset values (async, rst_n=0): uaddr=RESET_UADDR, ben=0, int_pend=0, mem_err=0, stack_err=0, wait counter=0, stack pointer=0.
- uaddr updates every cycle to next, with one-cycle latency. There is no stall input; waiting is expressed by self-loop microcode.
- Next-address priority, highest first:
  1. Timeout.
  2. c_ird: next = zero-extended ir[15:12].
  3. Call/return (feature only).
  4. COND modification of c_j.
- COND modification, applied as an OR into c_j:
  - 0: none.
  - 1: J[1] |= mem_rdy.
  - 2: J[2] |= ben.
  - 3: J[0] |= ir[11].
  - 4: J[3] |= int_pend.
  - 5: J[4] |= priv.
  - 6, 7: none unless the feature is enabled.
- BEN: when c_ld_ben=1, ben <= (ir[11]&cc_n)|(ir[10]&cc_z)|(ir[9]&cc_p). Otherwise ben holds.
- Interrupt pending: int_pend <= (int_pend & ~int_ack) | int_int. If int_ack and int_int are both high in the same cycle, int_pend stays 1.
- Wait counter:
  - Increments when c_cond=1 and mem_rdy=0.
  - Clears otherwise, including whenever mem_rdy=1.
  - Saturates; it never wraps.
- Timeout: when c_cond=1, mem_rdy=0 and the counter equals MEM_TIMEOUT-1:
  - next = ERR_UADDR, and mem_err <= 1.
  - The counter clears.
  - mem_err clears only on reset.
- mem_rdy rising on the exact timeout cycle takes priority over the timeout: no error, normal COND path.
- Reset asserted mid-wait or mid-call discards all state immediately, without waiting for a clock edge.

Optional Feature:
- Macro LC3_USEQ_CALL_STACK_EN.
- Defined:
  - COND=7 is a call: next = c_j, and uaddr+1 (modulo 2^UADDR_W) is pushed.
  - COND=6 is a return: next = popped entry.
  - A push when full is dropped (next still c_j) and sets stack_err.
  - A pop when empty gives next = RESET_UADDR and sets stack_err.
  - STACK_DEPTH entries, LIFO.
- Undefined:
  - COND 6/7 behave as COND 0.
  - No stack storage is built, and stack_err is tied 0.

Decomposition:
- Shared package lc3_pkg holds:
  - COND encodings (COND_UNCOND, COND_MEMRDY, COND_BEN, COND_ADDRMODE, COND_INT, COND_PRIV, COND_RET, COND_CALL).
  - J-bit OR positions.
  - The opcode field slice constants.
- Sub-module lc3_ustack: a parametrised LIFO with push/pop/full/empty, instantiated only under the macro.

Test Plan:
- Reset, then rst_n high with c_cond=0, c_j=33 → uaddr=18 during reset, uaddr=33 one clock later.
- c_ird=1, ir=16'h1000 (ADD) → next uaddr=1. ir=16'hF025 → uaddr=15.
- ir=16'h0400, cc_z=1, c_ld_ben=1; next cycle c_cond=2, c_j=0 → ben=1, uaddr=4. Repeat with cc_z=0, cc_p=1 → uaddr=0.
- c_cond=1, c_j=28, mem_rdy low for 3 cycles then high → uaddr 28,28,28,30. mem_err=0.
- c_cond=1, mem_rdy held low 16 cycles (MEM_TIMEOUT=16) → uaddr=63 on 16th edge, mem_err=1 and stays 1.
- With macro: call to 40 from uaddr 10 → uaddr=40. Return → uaddr=11. Five nested calls with depth 4 → stack_err=1. Return on empty stack → uaddr=18.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 microsequencer definitions: COND encodings, J-field OR
// positions and the opcode slice used for IRD dispatch.
package lc3_pkg;

  typedef enum logic [2:0] {
    COND_UNCOND   = 3'd0,
    COND_MEMRDY   = 3'd1,
    COND_BEN      = 3'd2,
    COND_ADDRMODE = 3'd3,
    COND_INT      = 3'd4,
    COND_PRIV     = 3'd5,
    COND_RET      = 3'd6,
    COND_CALL     = 3'd7
  } cond_e;

  // Bit of J that each branch condition ORs into
  localparam int unsigned JBIT_ADDRMODE = 0;
  localparam int unsigned JBIT_MEMRDY   = 1;
  localparam int unsigned JBIT_BEN      = 2;
  localparam int unsigned JBIT_INT      = 3;
  localparam int unsigned JBIT_PRIV     = 4;

  // Opcode field of the instruction register
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;

  // Branch-enable from IR[11:9] (n,z,p mask) and the condition codes
  function automatic logic ben_eval(input logic [15:0] ir,
                                    input logic n, input logic z, input logic p);
    return (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
  endfunction

endpackage

// File: rtl/lc3_ustack.sv
// Parametrised LIFO holding micro-call return addresses.
// Pushes when full and pops when empty are ignored; the caller flags them.
module lc3_ustack #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SPW-1:0]   sp_q, sp_d;
  logic [SPW-1:0]   top;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign top     = sp_q - SPW'(1);
  assign dout_o  = mem_q[top[AW-1:0]];

  // Stack pointer next-state
  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o)
      sp_d = sp_q + SPW'(1);
    else if (pop_i && !empty_o)
      sp_d = sp_q - SPW'(1);
  end

  // Stack pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // Entry storage; contents are meaningless until pushed, so no reset
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[sp_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/lc3_useq.sv
// LC-3 microsequencer: registered micro-address, BEN latch, interrupt
// pending latch and memory-wait timeout.
// Optional micro-call stack: define LC3_USEQ_CALL_STACK_EN.
module lc3_useq
  import lc3_pkg::*;
#(
  parameter int unsigned UADDR_W     = 6,
  parameter int unsigned RESET_UADDR = 18,
  parameter int unsigned ERR_UADDR   = 63,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               c_ird,
  input  logic [2:0]         c_cond,
  input  logic [UADDR_W-1:0] c_j,
  input  logic               c_ld_ben,
  input  logic [15:0]        ir,
  input  logic               cc_n,
  input  logic               cc_z,
  input  logic               cc_p,
  input  logic               priv,
  input  logic               mem_rdy,
  input  logic               int_int,
  input  logic               int_ack,
  output logic [UADDR_W-1:0] uaddr,
  output logic               ben,
  output logic               int_pend,
  output logic               mem_err,
  output logic               stack_err
);

  localparam int unsigned CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  logic [UADDR_W-1:0] uaddr_q, uaddr_d, jmod;
  logic               ben_q, ben_d;
  logic               int_pend_q, int_pend_d;
  logic               mem_err_q, mem_err_d;
  logic [CW-1:0]      wait_q, wait_d;
  logic               mem_wait, timeout;
  cond_e              cond;
  logic               unused_ir;

  assign unused_ir = ^ir[8:0];

`ifdef LC3_USEQ_CALL_STACK_EN
  logic               push, pop, stk_full, stk_empty;
  logic [UADDR_W-1:0] stk_top;
  logic               stack_err_q, stack_err_d;

  lc3_ustack #(
    .WIDTH (UADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_ustack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (uaddr_q + UADDR_W'(1)),
    .dout_o  (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  assign stack_err = stack_err_q;
`else
  assign stack_err = 1'b0;
`endif

  // Next micro-address, wait counter and latch updates
  always_comb begin
    cond     = cond_e'(c_cond);
    mem_wait = (cond == COND_MEMRDY) && !mem_rdy;
    timeout  = mem_wait && (wait_q == WAIT_LAST);

    jmod = c_j;
    case (cond)
      COND_MEMRDY:   jmod[JBIT_MEMRDY]   = c_j[JBIT_MEMRDY]   | mem_rdy;
      COND_BEN:      jmod[JBIT_BEN]      = c_j[JBIT_BEN]      | ben_q;
      COND_ADDRMODE: jmod[JBIT_ADDRMODE] = c_j[JBIT_ADDRMODE] | ir[11];
      COND_INT:      jmod[JBIT_INT]      = c_j[JBIT_INT]      | int_pend_q;
      COND_PRIV:     jmod[JBIT_PRIV]     = c_j[JBIT_PRIV]     | priv;
      default:       ;
    endcase

`ifdef LC3_USEQ_CALL_STACK_EN
    push        = !timeout && !c_ird && (cond == COND_CALL);
    pop         = !timeout && !c_ird && (cond == COND_RET);
    stack_err_d = stack_err_q | (push & stk_full) | (pop & stk_empty);
`endif

    if (timeout)
      uaddr_d = UADDR_W'(ERR_UADDR);
    else if (c_ird)
      uaddr_d = UADDR_W'(ir[OPC_MSB:OPC_LSB]);
`ifdef LC3_USEQ_CALL_STACK_EN
    else if (push)
      uaddr_d = c_j;
    else if (pop)
      uaddr_d = stk_empty ? UADDR_W'(RESET_UADDR) : stk_top;
`endif
    else
      uaddr_d = jmod;

    // Counter stops at WAIT_LAST; reaching it while still waiting is the timeout
    if (timeout || !mem_wait)
      wait_d = '0;
    else if (wait_q != WAIT_LAST)
      wait_d = wait_q + CW'(1);
    else
      wait_d = wait_q;

    mem_err_d  = mem_err_q | timeout;
    ben_d      = c_ld_ben ? ben_eval(ir, cc_n, cc_z, cc_p) : ben_q;
    int_pend_d = (int_pend_q & ~int_ack) | int_int;
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uaddr_q    <= UADDR_W'(RESET_UADDR);
      ben_q      <= 1'b0;
      int_pend_q <= 1'b0;
      mem_err_q  <= 1'b0;
      wait_q     <= '0;
    end else begin
      uaddr_q    <= uaddr_d;
      ben_q      <= ben_d;
      int_pend_q <= int_pend_d;
      mem_err_q  <= mem_err_d;
      wait_q     <= wait_d;
    end
  end

`ifdef LC3_USEQ_CALL_STACK_EN
  // Sticky stack over/underflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stack_err_q <= 1'b0;
    else        stack_err_q <= stack_err_d;
  end
`endif

  assign uaddr    = uaddr_q;
  assign ben      = ben_q;
  assign int_pend = int_pend_q;
  assign mem_err  = mem_err_q;

endmodule

// File: tb/tb_lc3_useq.sv
// Directed self-checking bench for lc3_useq (default parameters).
// Call-stack checks are selected by LC3_USEQ_CALL_STACK_EN.
module tb_lc3_useq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_ird, c_ld_ben, cc_n, cc_z, cc_p, priv, mem_rdy, int_int, int_ack;
  logic [2:0]  c_cond;
  logic [5:0]  c_j;
  logic [15:0] ir;
  logic [5:0]  uaddr;
  logic        ben, int_pend, mem_err, stack_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  lc3_useq #(
    .UADDR_W     (6),
    .RESET_UADDR (18),
    .ERR_UADDR   (63),
    .MEM_TIMEOUT (16),
    .STACK_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c_ird     (c_ird),
    .c_cond    (c_cond),
    .c_j       (c_j),
    .c_ld_ben  (c_ld_ben),
    .ir        (ir),
    .cc_n      (cc_n),
    .cc_z      (cc_z),
    .cc_p      (cc_p),
    .priv      (priv),
    .mem_rdy   (mem_rdy),
    .int_int   (int_int),
    .int_ack   (int_ack),
    .uaddr     (uaddr),
    .ben       (ben),
    .int_pend  (int_pend),
    .mem_err   (mem_err),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; c_ird = 1'b0; c_cond = 3'd0; c_j = 6'd33; c_ld_ben = 1'b0;
    ir = 16'h0000; cc_n = 1'b0; cc_z = 1'b0; cc_p = 1'b0; priv = 1'b0;
    mem_rdy = 1'b1; int_int = 1'b0; int_ack = 1'b0;

    // Reset values
    step(); step();
    check_eq("rst_uaddr", uaddr, 18);
    check_eq("rst_ben", ben, 0);
    check_eq("rst_int_pend", int_pend, 0);
    check_eq("rst_mem_err", mem_err, 0);
    check_eq("rst_stack_err", stack_err, 0);
    #2 rst_n = 1'b1;
    step();
    check_eq("first_j", uaddr, 33);

    // IRD dispatch
    c_ird = 1'b1; ir = 16'h1000;
    step(); check_eq("ird_add", uaddr, 1);
    ir = 16'hF025;
    step(); check_eq("ird_trap", uaddr, 15);
    c_ird = 1'b0;

    // BEN latch then COND=2
    ir = 16'h0400; cc_z = 1'b1; c_ld_ben = 1'b1; c_cond = 3'd0; c_j = 6'd0;
    step(); check_eq("ben_set", ben, 1);
    c_ld_ben = 1'b0; c_cond = 3'd2;
    step(); check_eq("cond_ben1", uaddr, 4);
    cc_z = 1'b0; cc_p = 1'b1; c_ld_ben = 1'b1; c_cond = 3'd0;
    step(); check_eq("ben_clr", ben, 0);
    c_ld_ben = 1'b0; c_cond = 3'd2;
    step(); check_eq("cond_ben0", uaddr, 0);
    cc_p = 1'b0;

    // Memory wait, ready on 4th cycle
    c_cond = 3'd1; c_j = 6'd28; mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_eq("memwait_loop", uaddr, 28);
    end
    mem_rdy = 1'b1;
    step(); check_eq("memwait_done", uaddr, 30);
    check_eq("memwait_noerr", mem_err, 0);

    // COND=3 addressing mode
    c_cond = 3'd3; c_j = 6'd32; ir = 16'h0800;
    step(); check_eq("cond_addrmode", uaddr, 33);

    // Interrupt latch and COND=4
    c_cond = 3'd0; c_j = 6'd0; int_int = 1'b1;
    step(); check_eq("int_set", int_pend, 1);
    int_int = 1'b0; c_cond = 3'd4;
    step(); check_eq("cond_int", uaddr, 8);
    check_eq("int_hold", int_pend, 1);
    c_cond = 3'd0; int_ack = 1'b1; int_int = 1'b1;
    step(); check_eq("int_ack_and_req", int_pend, 1);
    int_int = 1'b0;
    step(); check_eq("int_ack_clr", int_pend, 0);
    int_ack = 1'b0; c_cond = 3'd4;
    step(); check_eq("cond_int_none", uaddr, 0);

    // COND=5 privilege
    c_cond = 3'd5; priv = 1'b1;
    step(); check_eq("cond_priv", uaddr, 16);
    priv = 1'b0;

    // Ready arrives exactly on the would-be timeout cycle
    c_cond = 3'd1; c_j = 6'd20; mem_rdy = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check_eq("pre_timeout_loop", uaddr, 20);
    mem_rdy = 1'b1;
    step(); check_eq("rdy_beats_timeout", uaddr, 22);
    check_eq("rdy_beats_timeout_err", mem_err, 0);

    // Reset mid-wait clears the counter and state asynchronously
    mem_rdy = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst_uaddr", uaddr, 18);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check_eq("post_rst_no_timeout", uaddr, 20);
    check_eq("post_rst_no_err", mem_err, 0);
    mem_rdy = 1'b1;
    step();

    // Full timeout
    mem_rdy = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check_eq("timeout_edge15", uaddr, 20);
    step(); check_eq("timeout_uaddr", uaddr, 63);
    check_eq("timeout_err", mem_err, 1);
    // Counter restarts from zero after a timeout
    for (int i = 0; i < 15; i++) step();
    check_eq("timeout_rearm", uaddr, 20);
    mem_rdy = 1'b1; c_cond = 3'd0; c_j = 6'd5;
    step(); step();
    check_eq("err_sticky", mem_err, 1);

    // IRD outranks COND
    c_ird = 1'b1; ir = 16'h6000; c_cond = 3'd2; c_j = 6'd60;
    step(); check_eq("ird_priority", uaddr, 6);
    c_ird = 1'b0;

    // COND 6/7
    c_cond = 3'd0; c_j = 6'd10;
    step(); check_eq("pre_call", uaddr, 10);
`ifdef LC3_USEQ_CALL_STACK_EN
    c_cond = 3'd7; c_j = 6'd40;
    step(); check_eq("call", uaddr, 40);
    c_cond = 3'd6;
    step(); check_eq("ret", uaddr, 11);
    c_cond = 3'd7;
    for (int i = 0; i < 4; i++) begin
      c_j = 6'(41 + i);
      step();
    end
    check_eq("nest4_uaddr", uaddr, 44);
    check_eq("nest4_noerr", stack_err, 0);
    c_j = 6'd45;
    step(); check_eq("overflow_uaddr", uaddr, 45);
    check_eq("overflow_err", stack_err, 1);
    c_cond = 3'd6;
    step(); check_eq("pop1", uaddr, 44);
    step(); check_eq("pop2", uaddr, 43);
    step(); check_eq("pop3", uaddr, 42);
    step(); check_eq("pop4", uaddr, 12);
    step(); check_eq("underflow_uaddr", uaddr, 18);
    check_eq("underflow_err", stack_err, 1);
`else
    c_cond = 3'd7; c_j = 6'd40;
    step(); check_eq("cond7_plain", uaddr, 40);
    c_cond = 3'd6; c_j = 6'd5;
    step(); check_eq("cond6_plain", uaddr, 5);
    check_eq("stack_err_tied", stack_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
